// File: rtl/rv_pkg.sv
// Shared definitions for the RISC-V pipeline: datapath width, reset PC,
// sequential PC step and the machine word type.
package rv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_STEP  = 4;

    typedef logic [XLEN-1:0] word_t;

endpackage : rv_pkg

// File: rtl/wb_pc_reg.sv
// Program-counter register for the write-back stage. Selects the next PC
// (jump target or PC+4), registers it, and exports both the registered PC
// and the combinational next PC so the caller can form the link value.
// Optional build macro: WB_PC_ALIGN_EN -- clears bit 0 of the jump target
// (JALR semantics). Without it the target is taken unmodified.
module wb_pc_reg
    import rv_pkg::*;
#(
    parameter int unsigned       XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = rv_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   target,
    input  logic              pc_sel,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   next_pc
);

    logic [XLEN-1:0] jump_pc;
    logic [XLEN-1:0] seq_pc;

`ifdef WB_PC_ALIGN_EN
    assign jump_pc = {target[XLEN-1:1], 1'b0};
`else
    assign jump_pc = target;
`endif

    // Sequential step wraps modulo 2^XLEN with no carry out.
    assign seq_pc = pc + XLEN'(PC_STEP);

    // Next-PC mux: jump target or sequential increment.
    always_comb begin
        next_pc = seq_pc;
        if (pc_sel) begin
            next_pc = jump_pc;
        end
    end

    // PC register with synchronous reset; updates every edge, no stall.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

endmodule : wb_pc_reg

// File: rtl/wb_stage.sv
// Write-back stage: owns the PC register and produces the registered rd
// write data, chosen from the ALU result, memory load data or the link
// value (the PC being loaded this edge, plus 4).
// Optional build macro: WB_PC_ALIGN_EN (handled inside wb_pc_reg).
module wb_stage
    import rv_pkg::*;
#(
    parameter int unsigned       XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = rv_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   alu_i,
    input  logic [XLEN-1:0]   mem_i,
    input  logic              wb_sel1_i,
    input  logic              wb_sel2_i,
    input  logic              pc_sel_i,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   dataD_o
);

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] wb_next;
    logic [XLEN-1:0] wb;

    wb_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .target   (alu_i),
        .pc_sel   (pc_sel_i),
        .pc       (pc_o),
        .next_pc  (next_pc)
    );

    // Link value is taken from the PC loaded on this same edge.
    assign link = next_pc + XLEN'(PC_STEP);

    // rd source select: link overrides, otherwise ALU or memory.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no
        // latch is inferred when a branch below is not taken.
        wb_next = mem_i;
        if (wb_sel2_i) begin
            wb_next = link;
        end else if (wb_sel1_i) begin
            wb_next = alu_i;
        end
    end

    // rd data register with synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb <= '0;
        end else begin
            wb <= wb_next;
        end
    end

    assign dataD_o = wb;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a table of directed vectors covering
// reset, jump+link, ALU/memory select, sequential link, wrap and alignment
// and mid-run reset, followed by randomized stimulus checked against a
// cycle-level reference model. Honours WB_PC_ALIGN_EN when defined.
module tb_wb_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    word_t       alu_i;
    word_t       mem_i;
    logic        wb_sel1_i;
    logic        wb_sel2_i;
    logic        pc_sel_i;
    word_t       pc_o;
    word_t       dataD_o;

    int checks   = 0;
    int failures = 0;

    wb_stage dut (
        .clk       (clk),
        .rst       (rst),
        .alu_i     (alu_i),
        .mem_i     (mem_i),
        .wb_sel1_i (wb_sel1_i),
        .wb_sel2_i (wb_sel2_i),
        .pc_sel_i  (pc_sel_i),
        .pc_o      (pc_o),
        .dataD_o   (dataD_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  rst;
        word_t alu;
        word_t mem;
        logic  sel1;
        logic  sel2;
        logic  pcsel;
        word_t exp_pc;
        word_t exp_data;
    } vec_t;

    vec_t vecs[15];

    // Jump target as the build defines it.
    function automatic word_t tgt(input word_t x);
`ifdef WB_PC_ALIGN_EN
        return x & ~word_t'(1);
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(input logic r, input word_t a, input word_t m,
                                input logic s1, input logic s2, input logic ps,
                                input word_t ep, input word_t ed);
        vec_t v;
        v.rst = r; v.alu = a; v.mem = m; v.sel1 = s1; v.sel2 = s2;
        v.pcsel = ps; v.exp_pc = ep; v.exp_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input word_t actual, input word_t expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic r, input word_t a, input word_t m,
                         input logic s1, input logic s2, input logic ps);
        rst = r; alu_i = a; mem_i = m;
        wb_sel1_i = s1; wb_sel2_i = s2; pc_sel_i = ps;
    endtask

    // Reference model state: what the stage should hold after each edge.
    word_t m_pc;
    word_t m_data;

    task automatic model_step(input logic r, input word_t a, input word_t m,
                              input logic s1, input logic s2, input logic ps);
        word_t npc;
        if (r) begin
            m_pc   = RESET_PC;
            m_data = '0;
        end else begin
            npc    = ps ? tgt(a) : m_pc + 32'd4;
            m_data = s2 ? npc + 32'd4 : (s1 ? a : m);
            m_pc   = npc;
        end
    endtask

    initial begin
        word_t p5;
        p5 = tgt(32'd5);

        vecs[0]  = mk(1, 32'h1234_5678, 32'h9abc_def0, 1, 1, 1, 32'd0, 32'd0);
        vecs[1]  = mk(1, 32'hdead_beef, 32'h0bad_f00d, 0, 1, 0, 32'd0, 32'd0);
        vecs[2]  = mk(0, 32'h0000_0040, 32'h0000_0050, 0, 1, 0, 32'd4, 32'd8);
        vecs[3]  = mk(0, 32'd2, 32'd4, 1, 1, 1, tgt(32'd2), tgt(32'd2) + 32'd4);
        vecs[4]  = mk(0, 32'd5, 32'd6, 1, 0, 1, p5, 32'd5);
        vecs[5]  = mk(0, 32'd2, 32'd4, 0, 0, 0, p5 + 32'd4, 32'd4);
        vecs[6]  = mk(0, 32'd9, 32'd3, 1, 1, 0, p5 + 32'd8, p5 + 32'd12);
        vecs[7]  = mk(0, 32'd1, 32'hab, 0, 0, 0, p5 + 32'd12, 32'hab);
        vecs[8]  = mk(0, 32'hFFFF_FFFC, 32'd0, 1, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        vecs[9]  = mk(0, 32'd0, 32'd0, 0, 1, 0, 32'd0, 32'd4);
        vecs[10] = mk(0, 32'd7, 32'h55, 0, 0, 1, tgt(32'd7), 32'h55);
        vecs[11] = mk(0, 32'hFFFF_FFFC, 32'd0, 0, 1, 1, 32'hFFFF_FFFC, 32'd0);
        vecs[12] = mk(1, 32'h100, 32'h77, 1, 1, 1, 32'd0, 32'd0);
        vecs[13] = mk(0, 32'h100, 32'h77, 0, 1, 1, 32'h100, 32'h104);
        vecs[14] = mk(0, 32'h0, 32'h77, 0, 0, 0, 32'h104, 32'h77);

        drive(1, '0, '0, 0, 0, 0);
        @(negedge clk);

        // Directed table: drive on the falling edge, check one edge later.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].alu, vecs[i].mem,
                  vecs[i].sel1, vecs[i].sel2, vecs[i].pcsel);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_pc);
            check($sformatf("vec%0d_data", i), dataD_o, vecs[i].exp_data);
            @(negedge clk);
        end

        // Randomized phase: sync model to reset, then free-run.
        drive(1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        model_step(1, alu_i, mem_i, wb_sel1_i, wb_sel2_i, pc_sel_i);
        @(posedge clk);
        #1;
        check("rand_reset_pc", pc_o, m_pc);
        check("rand_reset_data", dataD_o, m_data);
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            logic  r;
            word_t a;
            r = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | word_t'($urandom_range(0, 15)))
                                            : word_t'($urandom);
            drive(r, a, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
            model_step(rst, alu_i, mem_i, wb_sel1_i, wb_sel2_i, pc_sel_i);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d_pc", i), pc_o, m_pc);
            check($sformatf("rand%0d_data", i), dataD_o, m_data);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_stage
